// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the clock-domain-crossing handshake sender.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2,
    ERR    = 2'd3
  } hs_state_t;

  // Width of a counter that must be able to hold the value 'timeout'.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop single-bit synchronizer for an asynchronous level input.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the flop chain; the first flop may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Sending side of a 4-phase req/ack handshake carrying a word to another clock domain.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_valid,
  input  logic [WIDTH-1:0] send_data,
  output logic             send_ready,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack,
  output logic             done,
  output logic             timeout_err,
  input  logic             err_clear
);

  localparam int             CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  hs_state_t        state;
  hs_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             req_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic             load;
  logic             ack_s;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (xfer_ack),
    .q    (ack_s)
  );

  // A stale ack still high would confuse the next handshake, so accepts wait for it to clear.
  assign send_ready = (state == IDLE) && !timeout_err && !ack_s;

  // Next-state logic: an exit condition always beats the timeout on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = xfer_req;
    done_nxt  = 1'b0;
    err_nxt   = timeout_err;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (send_valid && send_ready) begin
          load      = 1'b1;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ACK_LO;
        end else if (cnt == CNT_MAX) begin
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ACK_LO: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ERR: begin
        req_nxt = 1'b0;
        if (err_clear && !ack_s) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Control registers; reset withdraws req immediately without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      xfer_req    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      xfer_req    <= req_nxt;
      done        <= done_nxt;
      timeout_err <= err_nxt;
    end
  end

  // Payload register: loaded only on accept so it is stable for the whole handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_data <= '0;
    end else if (load) begin
      xfer_data <= send_data;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx: a cycle table for one handshake plus directed corner sequences.
module tb_cdc_hs_tx;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             send_valid;
  logic [WIDTH-1:0] send_data;
  logic             send_ready;
  logic             xfer_req;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_ack;
  logic             done;
  logic             timeout_err;
  logic             err_clear;

  logic remote_en;
  logic ack_man;
  logic ack_follow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       exp_req;
    logic       exp_done;
    logic       exp_rdy;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[10];

  cdc_hs_tx #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .xfer_ack   (xfer_ack),
    .done       (done),
    .timeout_err(timeout_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  // Remote side: acks one cycle after seeing req, drops one cycle after req falls.
  always @(posedge clk or posedge reset) begin
    if (reset) ack_follow <= 1'b0;
    else       ack_follow <= xfer_req;
  end

  assign xfer_ack = remote_en ? ack_follow : ack_man;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0] words[3];
    int idx, dones, cyc, last, hi_cnt, lat;
    logic prev;

    // Row k: inputs driven before edge N+k, outputs expected just after edge N+k.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[3] = '{1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[4] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[5] = '{1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[6] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[7] = '{1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[8] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[9] = '{1'b0, 8'h88, 1'b0, 1'b0, 1'b1, 8'hA5};

    reset      = 1'b1;
    send_valid = 1'b0;
    send_data  = '0;
    err_clear  = 1'b0;
    ack_man    = 1'b0;
    remote_en  = 1'b1;

    // Test 1: reset state, then one handshake checked cycle by cycle
    repeat (4) step;
    check("rst_req",   32'(xfer_req),    32'd0);
    check("rst_data",  32'(xfer_data),   32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);
    check("rst_ready", 32'(send_ready),  32'd1);
    reset = 1'b0;
    step;
    check("post_rst_ready", 32'(send_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      send_valid = tbl[i].vld;
      send_data  = tbl[i].din;
      step;
      check($sformatf("t1_req[%0d]", i),   32'(xfer_req),   32'(tbl[i].exp_req));
      check($sformatf("t1_done[%0d]", i),  32'(done),       32'(tbl[i].exp_done));
      check($sformatf("t1_ready[%0d]", i), 32'(send_ready), 32'(tbl[i].exp_rdy));
      check($sformatf("t1_data[%0d]", i),  32'(xfer_data),  32'(tbl[i].exp_data));
    end
    send_valid = 1'b0;

    // Test 2: three words back to back with send_valid held high
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    idx = 0; dones = 0; cyc = 0; last = 0;
    send_valid = 1'b1;
    send_data  = words[0];
    while ((idx < 3 || dones < 3) && cyc < 200) begin
      prev = xfer_req;
      step;
      cyc++;
      if (done) dones++;
      if (!prev && xfer_req) begin
        if (idx < 3) check($sformatf("t2_data[%0d]", idx), 32'(xfer_data), 32'(words[idx]));
        if (idx > 0) check($sformatf("t2_spacing[%0d]", idx), 32'(cyc - last), 32'd9);
        last = cyc;
        idx++;
        if (idx < 3) send_data = words[idx];
        else         send_valid = 1'b0;
      end
    end
    check("t2_budget",  32'(cyc < 200), 32'd1);
    check("t2_accepts", 32'(idx),       32'd3);
    check("t2_dones",   32'(dones),     32'd3);
    repeat (3) step;
    check("t2_idle_req",   32'(xfer_req),   32'd0);
    check("t2_idle_ready", 32'(send_ready), 32'd1);

    // Test 3: remote never acks; timeout after TIMEOUT+1 cycles, then clear
    remote_en = 1'b0;
    ack_man   = 1'b0;
    send_valid = 1'b1;
    send_data  = 8'h5B;
    step;
    send_valid = 1'b0;
    check("t3_req_rise", 32'(xfer_req), 32'd1);
    hi_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      step;
      if (xfer_req) hi_cnt++;
    end
    check("t3_req_held", 32'(hi_cnt),      32'd15);
    check("t3_err_early", 32'(timeout_err), 32'd0);
    step;
    check("t3_req_drop", 32'(xfer_req),    32'd0);
    check("t3_err",      32'(timeout_err), 32'd1);
    check("t3_ready",    32'(send_ready),  32'd0);
    repeat (3) step;
    check("t3_err_sticky", 32'(timeout_err), 32'd1);
    check("t3_data_held",  32'(xfer_data),   32'h5B);
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    check("t3_clr_err",   32'(timeout_err), 32'd0);
    check("t3_clr_ready", 32'(send_ready),  32'd1);

    // Test 4: err_clear ignored while ack is high, honoured once it is low
    send_valid = 1'b1;
    send_data  = 8'h66;
    step;
    send_valid = 1'b0;
    repeat (16) step;
    check("t4_err", 32'(timeout_err), 32'd1);
    ack_man = 1'b1;
    repeat (3) step;
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    check("t4_blocked_err",   32'(timeout_err), 32'd1);
    check("t4_blocked_ready", 32'(send_ready),  32'd0);
    check("t4_blocked_req",   32'(xfer_req),    32'd0);
    ack_man = 1'b0;
    repeat (SYNC_STAGES) step;
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    check("t4_clr_err",   32'(timeout_err), 32'd0);
    check("t4_clr_ready", 32'(send_ready),  32'd1);

    // Test 5: asynchronous reset in REQ_HI, then a fresh transfer
    remote_en  = 1'b1;
    send_valid = 1'b1;
    send_data  = 8'h77;
    step;
    send_valid = 1'b0;
    step;
    check("t5_pre_req", 32'(xfer_req), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_req",  32'(xfer_req),  32'd0);
    check("t5_async_done", 32'(done),      32'd0);
    check("t5_async_data", 32'(xfer_data), 32'd0);
    repeat (2) step;
    reset = 1'b0;
    step;
    send_valid = 1'b1;
    send_data  = 8'h3C;
    step;
    send_valid = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      step;
      lat++;
    end
    check("t5_latency", 32'(lat),       32'd8);
    check("t5_data",    32'(xfer_data), 32'h3C);
    step;
    check("t5_done_pulse", 32'(done), 32'd0);

    // Test 6: spurious ack in IDLE blocks accepts and data capture
    remote_en = 1'b0;
    ack_man   = 1'b1;
    repeat (3) step;
    check("t6_ready_blocked", 32'(send_ready), 32'd0);
    send_valid = 1'b1;
    send_data  = 8'hEE;
    repeat (4) step;
    check("t6_no_req",  32'(xfer_req),   32'd0);
    check("t6_no_data", 32'(xfer_data),  32'h3C);
    check("t6_ready",   32'(send_ready), 32'd0);
    send_valid = 1'b0;
    ack_man    = 1'b0;
    repeat (3) step;
    check("t6_ready_back", 32'(send_ready), 32'd1);
    check("t6_data_kept",  32'(xfer_data),  32'h3C);
    check("t6_req_low",    32'(xfer_req),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
